// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending stores drained to data memory by a
// two-state FSM, with load-address forwarding/stall (forwarding: STORE_BUFFER_FWD_EN).
module store_buffer #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [addr_width-1:0]     enq_addr,
    input  logic [data_width-1:0]     enq_data,
    input  logic [2:0]                enq_funct3,
    output logic                      mem_we,
    output logic [addr_width-1:0]     mem_addr,
    output logic [data_width-1:0]     mem_wdata,
    output logic [2:0]                mem_funct3,
    input  logic                      mem_ack,
    input  logic [addr_width-1:0]     lookup_addr,
    output logic                      fwd_hit,
    output logic [data_width-1:0]     fwd_data,
    output logic                      fwd_stall,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   head_reg, tail_reg;
    logic [CW-1:0]   count_reg, count_next;
    logic            do_enq, do_ret;

    logic [addr_width-1:0] addr_mem [DEPTH];
    logic [data_width-1:0] data_mem [DEPTH];
    logic [2:0]            f3_mem   [DEPTH];

    logic [PW-1:0]   age [DEPTH];
    logic [DEPTH-1:0] match;
    logic            any_match;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   best_age;

    // Sub-word address bits play no part in word-granular matching.
    logic unused_lookup_lsbs;
    assign unused_lookup_lsbs = ^lookup_addr[1:0];

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign enq_ready = !full;
    assign count     = count_reg;

    assign do_enq = enq_valid && !full;
    assign do_ret = (state_reg == WRITE) && mem_ack;

    assign mem_addr   = addr_mem[head_reg];
    assign mem_wdata  = data_mem[head_reg];
    assign mem_funct3 = f3_mem[head_reg];

    always_comb begin
        count_next = count_reg;
        if (do_enq && !do_ret)
            count_next = count_reg + CW'(1);
        else if (!do_enq && do_ret)
            count_next = count_reg - CW'(1);
    end

    always_comb begin
        state_next = state_reg;
        mem_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty)
                    state_next = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                if (do_ret && count_next == '0)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (do_ret)
                head_reg <= head_reg + PW'(1);
            if (do_enq)
                tail_reg <= tail_reg + PW'(1);
        end
    end

    // Entry storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            addr_mem[tail_reg] <= enq_addr;
            data_mem[tail_reg] <= enq_data;
            f3_mem[tail_reg]   <= enq_funct3;
        end
    end

    // Age 0 is the head (oldest); a slot is live when its age is below count.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign age[gi]   = PW'(gi) - head_reg;
            assign match[gi] = ({1'b0, age[gi]} < count_reg) &&
                               (addr_mem[gi][addr_width-1:2] == lookup_addr[addr_width-1:2]);
        end
    endgenerate

    always_comb begin
        any_match = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i] && (!any_match || age[i] > best_age)) begin
                any_match = 1'b1;
                best_age  = age[i];
                sel_idx   = PW'(i);
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    always_comb begin
        fwd_hit   = any_match && (f3_mem[sel_idx] == 3'b010);
        fwd_stall = any_match && (f3_mem[sel_idx] != 3'b010);
        fwd_data  = fwd_hit ? data_mem[sel_idx] : '0;
    end
`else
    logic unused_sel;
    assign unused_sel = ^sel_idx;
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
    assign fwd_stall  = any_match;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [31:0] enq_addr = '0;
    logic [31:0] enq_data = '0;
    logic [2:0]  enq_funct3 = '0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic        mem_ack = 1'b0;
    logic [31:0] lookup_addr = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_stall;
    logic        empty;
    logic        full;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  f;
    } ent_t;

    ent_t q[$];
    bit   in_write = 1'b0;

    always #5 clk = ~clk;

    store_buffer #(.addr_width(32), .data_width(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_addr(enq_addr), .enq_data(enq_data), .enq_funct3(enq_funct3),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_ack(mem_ack),
        .lookup_addr(lookup_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .fwd_stall(fwd_stall), .empty(empty), .full(full), .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int          n;
        bit          m_any;
        logic [2:0]  m_f;
        logic [31:0] m_d;
        logic        e_hit, e_stall;
        logic [31:0] e_data;
        n = q.size();
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("full", 64'(full), 64'(n == 4));
        chk("enq_ready", 64'(enq_ready), 64'(n != 4));
        chk("mem_we", 64'(mem_we), 64'(in_write));
        if (in_write && n > 0) begin
            chk("mem_addr", 64'(mem_addr), 64'(q[0].a));
            chk("mem_wdata", 64'(mem_wdata), 64'(q[0].d));
            chk("mem_funct3", 64'(mem_funct3), 64'(q[0].f));
        end
        m_any = 1'b0;
        m_f = '0;
        m_d = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!m_any && q[i].a[31:2] == lookup_addr[31:2]) begin
                m_any = 1'b1;
                m_f = q[i].f;
                m_d = q[i].d;
            end
        end
`ifdef STORE_BUFFER_FWD_EN
        e_hit   = m_any && (m_f == 3'b010);
        e_stall = m_any && (m_f != 3'b010);
        e_data  = e_hit ? m_d : 32'h0;
`else
        e_hit   = 1'b0;
        e_stall = m_any;
        e_data  = 32'h0;
`endif
        chk("fwd_hit", 64'(fwd_hit), 64'(e_hit));
        chk("fwd_stall", 64'(fwd_stall), 64'(e_stall));
        chk("fwd_data", 64'(fwd_data), 64'(e_data));
    endtask

    // One clock cycle: drive inputs, check at negedge, advance model across the edge.
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, input bit ack, input logic [31:0] lk);
        int   n0;
        bit   ret;
        ent_t e;
        enq_valid   = v;
        enq_addr    = a;
        enq_data    = d;
        enq_funct3  = f;
        mem_ack     = ack;
        lookup_addr = lk;
        @(negedge clk);
        check_outputs();
        $display("step v=%0d a=%h d=%h f=%0d ack=%0d lk=%h -> cnt=%0d we=%0d hit=%0d stall=%0d",
                 v, a, d, f, ack, lk, count, mem_we, fwd_hit, fwd_stall);
        n0  = q.size();
        ret = in_write && ack;
        if (ret) void'(q.pop_front());
        if (v && n0 < 4) begin
            e.a = a; e.d = d; e.f = f;
            q.push_back(e);
        end
        in_write = in_write ? (q.size() != 0) : (n0 != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ack, input logic [31:0] lk);
        step(1'b0, 32'h0, 32'h0, 3'b000, ack, lk);
    endtask

    task automatic drain();
        int budget = 20;
        while ((q.size() != 0 || in_write) && budget > 0) begin
            idle(1'b1, 32'h0);
            budget--;
        end
        chk("drain_budget", 64'(budget > 0), 64'(1));
    endtask

    initial begin
        // Reset state, before any clock edge
        #1 rst = 1'b1;
        #2;
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_enq_ready", 64'(enq_ready), 64'(1));
        chk("rst_fwd_hit", 64'(fwd_hit), 64'(0));
        chk("rst_fwd_stall", 64'(fwd_stall), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Single word store, one-cycle latency, ack returns to idle
        step(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1'b0, 32'h0);
        idle(1'b0, 32'h0);
        chk("lat_mem_we", 64'(mem_we), 64'(1));
        chk("lat_mem_addr", 64'(mem_addr), 64'(32'h100));
        idle(1'b1, 32'h0);
        idle(1'b0, 32'h0);
        chk("after_ack_empty", 64'(empty), 64'(1));

        // Fill to full, drop 5th, full+ack rejects enqueue, non-full+ack keeps count
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h400 + 32'(i * 4), 32'hA000_0000 + 32'(i), 3'b010, 1'b0, 32'h0);
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_ready", 64'(enq_ready), 64'(0));
        step(1'b1, 32'h500, 32'hBAD0BAD0, 3'b010, 1'b0, 32'h0);
        chk("drop5_count", 64'(count), 64'(4));
        step(1'b1, 32'h504, 32'hBAD1BAD1, 3'b010, 1'b1, 32'h0);
        chk("full_ack_count", 64'(count), 64'(3));
        step(1'b1, 32'h508, 32'hC0DEC0DE, 3'b010, 1'b1, 32'h0);
        chk("nonfull_ack_count", 64'(count), 64'(3));
        drain();

        // Forwarding: youngest of two same-address words wins
        step(1'b1, 32'h200, 32'h11111111, 3'b010, 1'b0, 32'h200);
        step(1'b1, 32'h200, 32'h22222222, 3'b010, 1'b0, 32'h200);
        idle(1'b0, 32'h200);
`ifdef STORE_BUFFER_FWD_EN
        chk("fwd_young_data", 64'(fwd_data), 64'(32'h22222222));
`else
        chk("fwd_young_stall", 64'(fwd_stall), 64'(1));
`endif
        drain();

        // Byte store to same word stalls in both builds
        step(1'b1, 32'h203, 32'h000000AB, 3'b000, 1'b0, 32'h200);
        idle(1'b0, 32'h200);
        chk("byte_stall", 64'(fwd_stall), 64'(1));
        chk("byte_hit", 64'(fwd_hit), 64'(0));
        drain();

        // Reset in the middle of WRITE with three pending entries
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h600 + 32'(i * 4), 32'h6000_0000 + 32'(i), 3'b010, 1'b0, 32'h0);
        chk("pre_rst_we", 64'(mem_we), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 64'(mem_we), 64'(0));
        chk("mid_rst_empty", 64'(empty), 64'(1));
        q.delete();
        in_write = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++)
            idle(1'b1, 32'h600);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, rl;
            logic [2:0]  rf;
            ra = 32'h300 + 32'(($urandom % 4) * 4) + 32'($urandom % 4);
            rl = 32'h300 + 32'(($urandom % 5) * 4) + 32'($urandom % 4);
            rf = 3'($urandom % 3);
            step(1'($urandom % 2), ra, $urandom, rf, ($urandom % 3) == 0, rl);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
